// File: rtl/hvac_pkg.sv
// Shared state encoding and default timing for the HVAC actuator sequencer.
package hvac_pkg;

   localparam int unsigned STATE_W         = 2;
   localparam int unsigned DEF_MIN_ON_CYC  = 8;
   localparam int unsigned DEF_MIN_OFF_CYC = 4;
   localparam int unsigned DEF_TIMER_W     = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      HEAT_ON = 2'd1,
      COOL_ON = 2'd2,
      REST    = 2'd3
   } state_e;

endpackage

// File: rtl/hvac_actuator_seq_hold_timer.sv
// Loadable saturating down-counter with a registered zero flag.
module hold_timer #(
   parameter int unsigned TIMER_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q, count_d;
   logic               zero_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= (count_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/hvac_actuator_seq.sv
// Heater/cooler sequencer with minimum on-time, anti-short-cycle rest and
// mutual exclusion between the two actuators.
module hvac_actuator_seq
   import hvac_pkg::*;
#(
   parameter int unsigned MIN_ON_CYC  = DEF_MIN_ON_CYC,
   parameter int unsigned MIN_OFF_CYC = DEF_MIN_OFF_CYC,
   parameter int unsigned TIMER_W     = DEF_TIMER_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               heat_req,
   input  logic               cool_req,
   output logic               heater_en,
   output logic               cooler_en,
   output logic               resting,
   output logic               req_conflict,
   output logic [STATE_W-1:0] state
);

   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(MIN_ON_CYC - 1);
   localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(MIN_OFF_CYC - 1);

   state_e             state_q, state_d;
   logic               heater_q, cooler_q, resting_q, conflict_q;
   logic               conflict_d;
   logic               tmr_load, tmr_dec, tmr_zero;
   logic [TIMER_W-1:0] tmr_load_val;
   logic               start_heat, start_cool, conflict;

   assign start_heat = enable & heat_req & ~cool_req;
   assign start_cool = enable & cool_req & ~heat_req;
   assign conflict   = enable & heat_req & cool_req;

   hold_timer #(.TIMER_W(TIMER_W)) u_hold_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   // Next-state logic; IDLE and an expired REST share the same start decision.
   always_comb begin
      state_d      = state_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;
      conflict_d   = 1'b0;
      unique case (state_q)
         IDLE, REST: begin
            if ((state_q == REST) && !tmr_zero) begin
               tmr_dec = 1'b1;
            end else if (start_heat) begin
               state_d      = HEAT_ON;
               tmr_load     = 1'b1;
               tmr_load_val = ON_LOAD;
            end else if (start_cool) begin
               state_d      = COOL_ON;
               tmr_load     = 1'b1;
               tmr_load_val = ON_LOAD;
            end else begin
               state_d    = IDLE;
               conflict_d = conflict;
            end
         end
         HEAT_ON, COOL_ON: begin
            if (!enable ||
                (tmr_zero && ((state_q == HEAT_ON) ? (~heat_req | cool_req)
                                                   : (~cool_req | heat_req)))) begin
               state_d      = REST;
               tmr_load     = 1'b1;
               tmr_load_val = OFF_LOAD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they align with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         heater_q   <= 1'b0;
         cooler_q   <= 1'b0;
         resting_q  <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         heater_q   <= (state_d == HEAT_ON);
         cooler_q   <= (state_d == COOL_ON);
         resting_q  <= (state_d == REST);
         conflict_q <= conflict_d;
      end
   end

   assign heater_en    = heater_q;
   assign cooler_en    = cooler_q;
   assign resting      = resting_q;
   assign req_conflict = conflict_q;
   assign state        = state_q;

endmodule

// File: tb/tb_hvac_actuator_seq.sv
// Scoreboard bench for hvac_actuator_seq with MIN_ON_CYC=4, MIN_OFF_CYC=3.
module tb_hvac_actuator_seq;

   localparam int unsigned MIN_ON  = 4;
   localparam int unsigned MIN_OFF = 3;

   typedef struct packed {
      logic       h;
      logic       c;
      logic       r;
      logic       cf;
      logic [1:0] st;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       heat_req = 1'b0;
   logic       cool_req = 1'b0;
   logic       heater_en, cooler_en, resting, req_conflict;
   logic [1:0] state;

   int   n_chk = 0;
   int   n_pass = 0;
   exp_t sbq[$];

   // reference model: state plus cycles already spent in it
   int   m_st = 0;
   int   m_age = 0;

   // run-length tracking of the observed enables
   logic prev_on = 1'b0;
   int   on_run = 0;
   int   off_run = 0;
   logic seen_fall = 1'b0;

   hvac_actuator_seq #(
      .MIN_ON_CYC  (MIN_ON),
      .MIN_OFF_CYC (MIN_OFF),
      .TIMER_W     (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .heat_req     (heat_req),
      .cool_req     (cool_req),
      .heater_en    (heater_en),
      .cooler_en    (cooler_en),
      .resting      (resting),
      .req_conflict (req_conflict),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_st = 0;
      m_age = 0;
      sbq.delete();
      prev_on = 1'b0;
      on_run = 0;
      off_run = 0;
      seen_fall = 1'b0;
   endtask

   // Compute what the DUT must show after the coming edge and queue it.
   task automatic model_push(input logic en, input logic h, input logic c);
      logic sh, sc, cf, own, other, conf;
      int   nst;
      exp_t e;
      sh = en & h & ~c;
      sc = en & c & ~h;
      cf = en & h & c;
      conf = 1'b0;
      nst = m_st;
      if (m_st == 0 || (m_st == 3 && m_age >= int'(MIN_OFF) - 1)) begin
         if (sh) nst = 1;
         else if (sc) nst = 2;
         else begin nst = 0; conf = cf; end
      end else if (m_st == 3) begin
         nst = 3;
      end else begin
         own   = (m_st == 1) ? h : c;
         other = (m_st == 1) ? c : h;
         if (!en || (m_age >= int'(MIN_ON) - 1 && (!own || other))) nst = 3;
      end
      m_age = (nst == m_st && m_st != 0) ? m_age + 1 : 0;
      m_st  = nst;
      e.h  = (nst == 1);
      e.c  = (nst == 2);
      e.r  = (nst == 3);
      e.cf = conf;
      e.st = 2'(nst);
      sbq.push_back(e);
   endtask

   // One clock: drive at the falling edge, compare 1 ns after the rising edge.
   task automatic cycle(input logic en, input logic h, input logic c);
      exp_t e;
      logic on;
      enable = en;
      heat_req = h;
      cool_req = c;
      model_push(en, h, c);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk("sb_underflow", 8'd1, 8'd0);
      end else begin
         e = sbq.pop_front();
         chk("heater_en", 8'(heater_en), 8'(e.h));
         chk("cooler_en", 8'(cooler_en), 8'(e.c));
         chk("resting", 8'(resting), 8'(e.r));
         chk("req_conflict", 8'(req_conflict), 8'(e.cf));
         chk("state", 8'(state), 8'(e.st));
      end
      chk("mutex", 8'(heater_en & cooler_en), 8'd0);
      on = heater_en | cooler_en;
      if (prev_on && !on) begin
         if (en) chk("min_on", 8'(on_run >= int'(MIN_ON)), 8'd1);
         seen_fall = 1'b1;
         off_run = 0;
      end
      if (!prev_on && on) begin
         if (seen_fall) chk("min_off", 8'(off_run >= int'(MIN_OFF)), 8'd1);
         on_run = 0;
      end
      if (on) on_run++;
      else off_run++;
      prev_on = on;
      @(negedge clk);
   endtask

   initial begin
      int cnt_h, cnt_r, cnt_cf, gap;

      // reset state before any clock edge
      #1;
      chk("rst_heater", 8'(heater_en), 8'd0);
      chk("rst_cooler", 8'(cooler_en), 8'd0);
      chk("rst_resting", 8'(resting), 8'd0);
      chk("rst_conflict", 8'(req_conflict), 8'd0);
      chk("rst_state", 8'(state), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) cycle(1'b1, 1'b0, 1'b0);

      // basic heat: one-cycle request
      cnt_h = 0;
      cnt_r = 0;
      cycle(1'b1, 1'b1, 1'b0);
      cnt_h += int'(heater_en);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         cnt_h += int'(heater_en);
         cnt_r += int'(resting);
      end
      chk("basic_on_cycles", 8'(cnt_h), 8'(MIN_ON));
      chk("basic_rest_cycles", 8'(cnt_r), 8'(MIN_OFF));
      chk("basic_idle", 8'(state), 8'd0);

      // changeover heat -> cool through REST
      repeat (10) cycle(1'b1, 1'b1, 1'b0);
      chk("chg_heat_on", 8'(heater_en), 8'd1);
      gap = 0;
      cycle(1'b1, 1'b0, 1'b1);
      chk("chg_heat_fall", 8'(heater_en), 8'd0);
      gap += int'(!heater_en && !cooler_en);
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, 1'b0, 1'b1);
         gap += int'(!heater_en && !cooler_en);
      end
      chk("chg_gap", 8'(gap), 8'(MIN_OFF));
      chk("chg_cool_on", 8'(cooler_en), 8'd1);
      repeat (12) cycle(1'b1, 1'b0, 1'b0);

      // conflict in IDLE
      cnt_cf = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         cnt_cf += int'(req_conflict);
      end
      chk("conflict_pulses", 8'(cnt_cf), 8'd5);
      chk("conflict_idle", 8'(state), 8'd0);
      cycle(1'b1, 1'b0, 1'b0);

      // enable kill at on-cycle 2, re-request during REST
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      chk("kill_heater", 8'(heater_en), 8'd0);
      cnt_r = int'(resting);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         cnt_r += int'(resting);
      end
      chk("kill_rest_cycles", 8'(cnt_r), 8'(MIN_OFF));
      chk("kill_reheat", 8'(heater_en), 8'd1);
      repeat (12) cycle(1'b1, 1'b0, 1'b0);

      // short-cycle guard: toggling cool request
      for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0, (i % 2) == 0);
      repeat (12) cycle(1'b1, 1'b0, 1'b0);

      // async reset mid HEAT_ON, between edges
      repeat (2) cycle(1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_heater", 8'(heater_en), 8'd0);
      chk("arst_state", 8'(state), 8'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      chk("arst_reheat", 8'(heater_en), 8'd1);
      repeat (12) cycle(1'b1, 1'b0, 1'b0);

      chk("sb_empty", 8'(sbq.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
